// File: rtl/instr_pkg.sv
// Shared types and constants for the RV32I immediate extender/encoder pair.
package instr_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_t;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // Occupancy of the output register / skid register pair.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational packer: scatters a sign-extended immediate into the I/S/B/J
// layout and flags immediates that do not fit or are misaligned.
module imm_pack
    import instr_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  immsrc_t     immsrc,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic range_err;

    always_comb begin
        instr     = '0;
        range_err = 1'b0;
        case (immsrc)
            IMM_I: begin
                instr     = {imm[11:0], rs1, funct3, rd, opcode};
                range_err = !((&imm[31:11]) || !(|imm[31:11]));
            end
            IMM_S: begin
                instr     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_err = !((&imm[31:11]) || !(|imm[31:11]));
            end
            IMM_B: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            IMM_J: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            default: begin
                instr     = '0;
                range_err = 1'b0;
            end
        endcase
    end

    // With checking disabled the truncated word goes out unflagged.
    assign err = CHECK_EN ? range_err : 1'b0;

endmodule

// File: rtl/instr_encoder.sv
// Valid/ready instruction encoder: packs fields into an RV32I word and
// delivers it through a two-entry (output + skid) buffer with delivery counters.
//
// state     | meaning
// BUF_EMPTY | nothing held, o_valid=0
// BUF_ONE   | output register holds the head entry, skid free
// BUF_TWO   | output and skid both hold entries, o_ready=0
module instr_encoder
    import instr_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_immsrc,
    input  logic [6:0]       i_opcode,
    input  logic [4:0]       i_rd,
    input  logic [2:0]       i_funct3,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic [31:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_instr,
    output logic             o_err,
    output logic [CNT_W-1:0] o_enc_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_t  state;
    buf_state_t  state_nxt;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic [31:0] out_instr;
    logic        out_err;
    logic [31:0] skid_instr;
    logic        skid_err;
    logic        load_out;
    logic        out_from_skid;
    logic        load_skid;
    logic        accept;
    logic        consume;

    imm_pack #(
        .CHECK_EN (CHECK_EN)
    ) u_imm_pack (
        .immsrc (immsrc_t'(i_immsrc)),
        .opcode (i_opcode),
        .rd     (i_rd),
        .funct3 (i_funct3),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .imm    (i_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    // Both flags decode the state register only, so i_ready never reaches o_ready.
    assign o_valid = (state != BUF_EMPTY);
    assign o_ready = (state != BUF_TWO);
    assign o_instr = out_instr;
    assign o_err   = out_err;
    assign accept  = i_valid && o_ready;
    assign consume = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    load_out  = 1'b1;
                    state_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = BUF_TWO;
                end else if (consume) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (consume) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_nxt     = BUF_ONE;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_instr  <= '0;
            out_err    <= 1'b0;
            skid_instr <= '0;
            skid_err   <= 1'b0;
        end else begin
            if (load_out) begin
                out_instr <= out_from_skid ? skid_instr : pack_instr;
                out_err   <= out_from_skid ? skid_err   : pack_err;
            end
            if (load_skid) begin
                skid_instr <= pack_instr;
                skid_err   <= pack_err;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_enc_count <= '0;
            o_err_count <= '0;
        end else if (consume) begin
            if (o_enc_count != CNT_MAX) begin
                o_enc_count <= o_enc_count + CNT_W'(1);
            end
            if (out_err && (o_err_count != CNT_MAX)) begin
                o_err_count <= o_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a queue-based reference model predicts
// every output word, flag and counter, including unchecked and narrow-counter builds.
module tb_instr_encoder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [1:0]  i_immsrc;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [31:0] i_imm;
    logic        i_ready;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_instr;
    logic [15:0] o_enc_count, o_err_count;

    logic        nc_ready, nc_valid, nc_err;
    logic [31:0] nc_instr;
    logic [15:0] nc_enc_count, nc_err_count;

    logic        sat_ready, sat_valid, sat_err;
    logic [31:0] sat_instr;
    logic [1:0]  sat_enc_count, sat_err_count;

    always #5 i_clk = ~i_clk;

    instr_encoder #(.CNT_W(16), .CHECK_EN(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_immsrc(i_immsrc), .i_opcode(i_opcode), .i_rd(i_rd), .i_funct3(i_funct3),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_valid(o_valid),
        .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
        .o_enc_count(o_enc_count), .o_err_count(o_err_count)
    );

    instr_encoder #(.CNT_W(16), .CHECK_EN(1'b0)) dut_nc (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(nc_ready),
        .i_immsrc(i_immsrc), .i_opcode(i_opcode), .i_rd(i_rd), .i_funct3(i_funct3),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_valid(nc_valid),
        .i_ready(i_ready), .o_instr(nc_instr), .o_err(nc_err),
        .o_enc_count(nc_enc_count), .o_err_count(nc_err_count)
    );

    instr_encoder #(.CNT_W(2), .CHECK_EN(1'b1)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(sat_ready),
        .i_immsrc(i_immsrc), .i_opcode(i_opcode), .i_rd(i_rd), .i_funct3(i_funct3),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .o_valid(sat_valid),
        .i_ready(i_ready), .o_instr(sat_instr), .o_err(sat_err),
        .o_enc_count(sat_enc_count), .o_err_count(sat_err_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  fmt;
        logic [31:0] imm;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   enc_n = 0;
    int   err_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pack(input logic [1:0] fmt, input logic [6:0] op,
                                               input logic [4:0] rd, input logic [2:0] f3,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm);
        logic [31:0] x, common;
        x      = imm;
        common = 32'(op);
        case (fmt)
            2'd0: return ((x & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                         | (32'(rd) << 7) | common;
            2'd1: return (((x >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                         | (32'(f3) << 12) | ((x & 32'h1F) << 7) | common;
            2'd2: return (((x >> 12) & 32'h1) << 31) | (((x >> 5) & 32'h3F) << 25)
                         | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                         | (((x >> 1) & 32'hF) << 8) | (((x >> 11) & 32'h1) << 7) | common;
            default: return (((x >> 20) & 32'h1) << 31) | (((x >> 1) & 32'h3FF) << 21)
                         | (((x >> 11) & 32'h1) << 20) | (((x >> 12) & 32'hFF) << 12)
                         | (32'(rd) << 7) | common;
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] fmt, input logic [31:0] imm);
        int s;
        s = signed'(imm);
        case (fmt)
            2'd0, 2'd1: return (s < -2048) || (s > 2047);
            2'd2:       return (s < -4096) || (s > 4095) || imm[0];
            default:    return (s < -1048576) || (s > 1048575) || imm[0];
        endcase
    endfunction

    // Immediate extender, used to confirm the packed word round-trips.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] fmt);
        case (fmt)
            2'd0: return {{20{w[31]}}, w[31:20]};
            2'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2'd2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_outputs();
        chk("valid", 32'(o_valid), 32'(q.size() > 0));
        chk("ready", 32'(o_ready), 32'(q.size() < 2));
        chk("nc_valid", 32'(nc_valid), 32'(q.size() > 0));
        chk("nc_ready", 32'(nc_ready), 32'(q.size() < 2));
        chk("sat_valid", 32'(sat_valid), 32'(q.size() > 0));
        chk("sat_ready", 32'(sat_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("instr", o_instr, q[0].instr);
            chk("err", 32'(o_err), 32'(q[0].err));
            chk("nc_instr", nc_instr, q[0].instr);
            chk("nc_err", 32'(nc_err), 32'd0);
            chk("sat_instr", sat_instr, q[0].instr);
            chk("sat_err", 32'(sat_err), 32'(q[0].err));
            if (!q[0].err) chk("roundtrip", extend(o_instr, q[0].fmt), q[0].imm);
        end
        chk("enc_count", 32'(o_enc_count), sat(enc_n, 65535));
        chk("err_count", 32'(o_err_count), sat(err_n, 65535));
        chk("nc_enc_count", 32'(nc_enc_count), sat(enc_n, 65535));
        chk("nc_err_count", 32'(nc_err_count), 32'd0);
        chk("sat_enc_count", 32'(sat_enc_count), sat(enc_n, 3));
        chk("sat_err_count", 32'(sat_err_count), sat(err_n, 3));
    endtask

    task automatic step();
        bit   acc, cons;
        ent_t e;
        acc = i_valid && (q.size() < 2);
        cons = i_ready && (q.size() > 0);
        e.fmt   = i_immsrc;
        e.imm   = i_imm;
        e.instr = model_pack(i_immsrc, i_opcode, i_rd, i_funct3, i_rs1, i_rs2, i_imm);
        e.err   = model_err(i_immsrc, i_imm);
        @(posedge i_clk);
        if (i_rst) begin
            q.delete();
            enc_n = 0;
            err_n = 0;
        end else begin
            if (cons) begin
                enc_n++;
                if (q[0].err) err_n++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic set_req(input logic [1:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        i_immsrc = fmt;
        i_opcode = op;
        i_rd     = rd;
        i_funct3 = f3;
        i_rs1    = rs1;
        i_rs2    = rs2;
        i_imm    = imm;
    endtask

    task automatic plan(input string tag, input logic [1:0] fmt, input logic [6:0] op,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
        set_req(fmt, op, rd, f3, rs1, rs2, imm);
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk({tag, "_instr"}, o_instr, exp_instr);
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        chk({tag, "_nc_err"}, 32'(nc_err), 32'd0);
        if (!exp_err) chk({tag, "_rt"}, extend(o_instr, fmt), imm);
        step();
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] picks [14];
        picks = '{32'h000007FF, 32'h00000800, 32'hFFFFF800, 32'hFFFFF7FF, 32'h00000FFE,
                  32'h00001000, 32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000,
                  32'hFFF00000, 32'hFFEFFFFE, 32'h00000001, 32'h00000000};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 8191)) - 32'd4096;
            2: return 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
            default: return picks[$urandom_range(0, 13)];
        endcase
    endfunction

    initial begin
        logic [31:0] a_instr;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        set_req(2'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        @(negedge i_clk);
        step();
        i_rst = 1'b0;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);

        plan("plan_i", 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        chk("plan_i_cnt", 32'(o_enc_count), 32'd1);
        plan("plan_s", 2'b01, 7'h23, 5'd0, 3'd2, 5'd5, 5'd6, 32'hFFFFF80A, 32'h8062A523, 1'b0);
        plan("plan_b", 2'b10, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'hFFFFF054, 32'h84000A63, 1'b0);
        plan("plan_j", 2'b11, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h0000A814, 32'h0150A0EF, 1'b0);
        plan("err_b", 2'b10, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 32'h00000003, 32'h00000163, 1'b1);
        plan("err_i", 2'b00, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'h00000800, 32'h80000093, 1'b1);
        chk("plan_err_count", 32'(o_err_count), 32'd2);
        chk("plan_enc_count", 32'(o_enc_count), 32'd6);

        // Backpressure: three offers against a stalled sink.
        i_ready = 1'b0;
        i_valid = 1'b1;
        set_req(2'b00, 7'h13, 5'd3, 3'd1, 5'd4, 5'd0, 32'h00000123);
        a_instr = model_pack(2'b00, 7'h13, 5'd3, 3'd1, 5'd4, 5'd0, 32'h00000123);
        step();
        chk("bp_ready1", 32'(o_ready), 32'd1);
        set_req(2'b01, 7'h23, 5'd0, 3'd2, 5'd7, 5'd8, 32'hFFFFFFF0);
        step();
        chk("bp_ready2", 32'(o_ready), 32'd0);
        set_req(2'b11, 7'h6F, 5'd9, 3'd0, 5'd0, 5'd0, 32'h00000400);
        step();
        chk("bp_hold", o_instr, a_instr);
        chk("bp_ready3", 32'(o_ready), 32'd0);
        step();
        chk("bp_hold2", o_instr, a_instr);
        i_ready = 1'b1;
        step();
        step();
        i_valid = 1'b0;
        step();
        step();
        chk("bp_count", 32'(o_enc_count), 32'd9);

        // Reset while two entries are held.
        i_ready = 1'b0;
        i_valid = 1'b1;
        step();
        step();
        chk("full_before_rst", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rst2_valid", 32'(o_valid), 32'd0);
        chk("rst2_ready", 32'(o_ready), 32'd1);
        chk("rst2_enc", 32'(o_enc_count), 32'd0);
        chk("rst2_errc", 32'(o_err_count), 32'd0);

        for (int i = 0; i < 800; i++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_rst   = ($urandom_range(0, 199) == 0);
            set_req(2'($urandom), 7'($urandom), 5'($urandom), 3'($urandom),
                    5'($urandom), 5'($urandom), rand_imm());
            step();
        end

        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        step();
        chk("drained", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate extender: packs a RISC-V RV32I instruction word from its decoded fields and a sign-extended 32-bit immediate.
- Scatters the immediate into the I, S, B or J bit layout selected by i_immsrc.
- Range- and alignment-checks the immediate and flags violations.
- Valid/ready streaming stage with a 2-entry output buffer. Sits between the test-program generator / instruction-memory loader and the instruction ROM writer; a round trip through the extender must return the original immediate.

Parameters:
- CNT_W, 16, width of the saturating encoded/error counters.
- CHECK_EN, 1, 1 = range/alignment checks active; 0 = o_err forced 0, immediate silently truncated.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  request valid.
- o_ready  output  1  encoder can accept a request (registered).
- i_immsrc  input  2  format: 00 I, 01 S, 10 B, 11 J (same encoding as the extender).
- i_opcode  input  7  instr[6:0].
- i_rd  input  5  destination register (I, J).
- i_funct3  input  3  instr[14:12] (I, S, B).
- i_rs1  input  5  source 1 (I, S, B).
- i_rs2  input  5  source 2 (S, B).
- i_imm  input  32  sign-extended immediate, byte offset for B/J.
- o_valid  output  1  packed instruction valid.
- i_ready  input  1  downstream accepts o_instr.
- o_instr  output  32  packed instruction.
- o_err  output  1  immediate out of range or misaligned; qualified by o_valid, travels with o_instr.
- o_enc_count  output  CNT_W  instructions delivered (output handshakes).
- o_err_count  output  CNT_W  delivered instructions with o_err=1.

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_valid=0, o_ready=1, o_instr=0, o_err=0, both counters 0.
  - Buffer emptied, including any entry mid-flight.
- Packing (combinational, before buffering):
  - I: imm[11:0] | rs1 | f3 | rd | op.
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
  - Fields unused by a format are ignored.
- Checks (CHECK_EN=1):
  - I/S error if imm[31:11] is not all-equal.
  - B error if imm[31:12] is not all-equal or imm[0]=1.
  - J error if imm[31:20] is not all-equal or imm[0]=1.
  - An erroneous request is still packed (truncated bits) and delivered with o_err=1; it is never dropped.
- Handshake:
  - Input accepted when i_valid && o_ready at an edge.
  - Output consumed when o_valid && i_ready at an edge.
  - o_valid/o_instr/o_err are stable while o_valid && !i_ready.
- Latency: a request accepted at edge N is presented at o_valid after edge N (1 cycle) when the buffer is empty.
- Buffer: 2 entries (output register plus skid register), strictly FIFO order.
  - o_ready = skid entry empty (registered; no combinational i_ready→o_ready path).
  - Full (2 entries, no consume): o_ready=0 and no accept.
  - Simultaneous accept and consume with 1 entry held: the new entry moves to the output register, occupancy stays 1.
  - Throughput is 1 per cycle under continuous i_ready=1.
- Counters:
  - o_enc_count increments on each output handshake.
  - o_err_count increments on each output handshake with o_err=1.
  - Both saturate at 2^CNT_W-1 with no wrap.

Decomposition:
- Shared package instr_pkg:
  - immsrc_t enum (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11), shared with the extender.
  - Opcode constants (OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_JAL=7'h6F).
- One sub-module, imm_pack: purely combinational; implements packing and checking, outputs instr and err.
- instr_encoder holds the handshake buffer and counters.

Test Plan:
- Format I, opcode 0x13, rd=1, rs1=0, f3=0, imm=0xFFFFF800, i_ready=1 → o_instr=0x80000093 and o_err=0 one cycle after accept; o_enc_count=1.
- Format S, opcode 0x23, f3=2, rs1=5, rs2=6, imm=0xFFFFF80A → o_instr=0x8062A523, o_err=0.
- Format B, opcode 0x63, rs1=rs2=0, f3=0, imm=0xFFFFF054 → o_instr=0x84000A63; feeding 0x84000A63 into the extender with immsrc=10 returns 0xFFFFF054.
- Format J, opcode 0x6F, rd=1, imm=0x0000A814 → o_instr=0x0150A0EF.
- Error cases:
  - Format B, imm=0x00000003 → o_err=1.
  - Format I, imm=0x00000800 → o_err=1.
  - Result: o_err_count=2, both instructions still delivered.
  - With CHECK_EN=0 the same stimulus gives o_err=0.
- Backpressure and reset:
  - Hold i_ready=0 and offer 3 back-to-back requests → 2 accepted, o_ready=0 from the cycle after the second accept, o_instr stable.
  - Release i_ready → outputs appear in order, then the third request is accepted.
  - Assert i_rst with 2 entries held → o_valid=0, o_ready=1, counters 0 on the next cycle.
